// File: rtl/alarm_responder_if.sv
// Signal bundle between the alarm responder and its surroundings: sensor-side
// inputs plus the siren/status outputs.
interface alarm_responder_if;
  logic       alarm_in;
  logic [3:0] sensors_in;
  logic       arm;
  logic       ack;
  logic       clear_count;
  logic       siren;
  logic       alarm_active;
  logic [3:0] zone;
  logic [7:0] event_count;
  logic [2:0] state;

  modport master (
    output alarm_in, sensors_in, arm, ack, clear_count,
    input  siren, alarm_active, zone, event_count, state
  );

  modport slave (
    input  alarm_in, sensors_in, arm, ack, clear_count,
    output siren, alarm_active, zone, event_count, state
  );
endinterface

// File: rtl/alarm_responder.sv
// Alarm responder: synchronizes and debounces the alarm line, drives a siren
// square wave until acknowledged, and records the zone and alarm count.
module alarm_responder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SIREN_HALF      = 8
) (
  input logic               clk,
  input logic               rst,
  alarm_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    IDLE     = 3'd1,
    DEBOUNCE = 3'd2,
    ALARM    = 3'd3,
    ACKED    = 3'd4
  } state_t;

  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] SIREN_LAST = 8'(SIREN_HALF - 1);

  state_t     state_q, state_d;
  logic [1:0] sync_q;
  logic       alarm_s;
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic       enter_alarm;
  logic       siren_q;
  logic [7:0] siren_cnt_q;
  logic       alarm_active_q;
  logic [3:0] zone_q;
  logic [7:0] event_count_q;

  assign alarm_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    enter_alarm = 1'b0;
    case (state_q)
      DISARMED: begin
        if (bus.arm) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.arm) begin
          state_d = DISARMED;
        end else if (alarm_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ALARM;
          end else begin
            state_d   = DEBOUNCE;
            deb_cnt_d = 4'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!bus.arm) begin
          state_d   = DISARMED;
          deb_cnt_d = 4'd0;
        end else if (!alarm_s) begin
          state_d   = IDLE;
          deb_cnt_d = 4'd0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ALARM;
          deb_cnt_d = 4'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 4'd1;
        end
      end
      ALARM: begin
        if (bus.ack) state_d = ACKED;
      end
      ACKED: begin
        if (!alarm_s) state_d = bus.arm ? IDLE : DISARMED;
      end
      default: state_d = DISARMED;
    endcase
    enter_alarm = (state_d == ALARM) && (state_q != ALARM);
  end

  // Siren phase restarts high on entry to ALARM and is forced low elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DISARMED;
      sync_q         <= 2'b00;
      deb_cnt_q      <= 4'd0;
      siren_q        <= 1'b0;
      siren_cnt_q    <= 8'd0;
      alarm_active_q <= 1'b0;
      zone_q         <= 4'd0;
      event_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      sync_q         <= {sync_q[0], bus.alarm_in};
      deb_cnt_q      <= deb_cnt_d;
      alarm_active_q <= (state_d == ALARM);
      if (enter_alarm) begin
        siren_q     <= 1'b1;
        siren_cnt_q <= 8'd0;
        zone_q      <= bus.sensors_in;
      end else if (state_d == ALARM) begin
        if (siren_cnt_q == SIREN_LAST) begin
          siren_q     <= ~siren_q;
          siren_cnt_q <= 8'd0;
        end else begin
          siren_cnt_q <= siren_cnt_q + 8'd1;
        end
      end else begin
        siren_q     <= 1'b0;
        siren_cnt_q <= 8'd0;
      end
      if (bus.clear_count) begin
        event_count_q <= 8'd0;
      end else if (enter_alarm && event_count_q != 8'hFF) begin
        event_count_q <= event_count_q + 8'd1;
      end
    end
  end

  assign bus.siren        = siren_q;
  assign bus.alarm_active = alarm_active_q;
  assign bus.zone         = zone_q;
  assign bus.event_count  = event_count_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Self-checking bench for alarm_responder: a cycle model feeds a scoreboard
// queue each cycle, plus directed checks of latency, siren shape and counting.
module tb_alarm_responder;

  localparam int DEB = 4;
  localparam int SH  = 8;

  logic clk;
  logic rst;

  alarm_responder_if bus ();

  alarm_responder #(.DEBOUNCE_CYCLES(DEB), .SIREN_HALF(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       sir;
    logic       act;
    logic [3:0] zone;
    logic [7:0] ev;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  logic       t_rst   = 1'b1;
  logic       t_alarm = 1'b0;
  logic [3:0] t_sens  = 4'd0;
  logic       t_arm   = 1'b0;
  logic       t_ack   = 1'b0;
  logic       t_clr   = 1'b0;

  int m_st, m_s1, m_s2, m_cnt, m_age, m_zone, m_ev;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour: advance one clock using the inputs about to be sampled.
  task automatic modelStep();
    exp_t e;
    int st_n, cnt_n, age_n;
    bit enter;
    if (t_rst) begin
      m_st = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_age = 0; m_zone = 0; m_ev = 0;
    end else begin
      st_n = m_st; cnt_n = m_cnt; age_n = m_age + 1; enter = 0;
      case (m_st)
        0: if (t_arm) st_n = 1;
        1: if (!t_arm) st_n = 0;
           else if (m_s2 != 0) begin
             if (DEB == 1) begin st_n = 3; enter = 1; end
             else begin st_n = 2; cnt_n = 1; end
           end
        2: if (!t_arm) begin st_n = 0; cnt_n = 0; end
           else if (m_s2 == 0) begin st_n = 1; cnt_n = 0; end
           else if (m_cnt == DEB) begin st_n = 3; cnt_n = 0; enter = 1; end
           else cnt_n = m_cnt + 1;
        3: if (t_ack) st_n = 4;
        4: if (m_s2 == 0) st_n = t_arm ? 1 : 0;
        default: st_n = 0;
      endcase
      if (enter) begin
        age_n  = 0;
        m_zone = int'(t_sens);
      end
      if (t_clr) m_ev = 0;
      else if (enter && m_ev < 255) m_ev++;
      m_s2 = m_s1; m_s1 = int'(t_alarm);
      m_st = st_n; m_cnt = cnt_n; m_age = age_n;
    end
    e.st   = 3'(m_st);
    e.act  = (m_st == 3);
    e.sir  = (m_st == 3) && (((m_age / SH) % 2) == 0);
    e.zone = 4'(m_zone);
    e.ev   = 8'(m_ev);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int cycles = 1);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      rst             = t_rst;
      bus.alarm_in    = t_alarm;
      bus.sensors_in  = t_sens;
      bus.arm         = t_arm;
      bus.ack         = t_ack;
      bus.clear_count = t_clr;
      modelStep();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checkOutput("sb_state", 32'(bus.state), 32'(e.st));
      checkOutput("sb_siren", 32'(bus.siren), 32'(e.sir));
      checkOutput("sb_active", 32'(bus.alarm_active), 32'(e.act));
      checkOutput("sb_zone", 32'(bus.zone), 32'(e.zone));
      checkOutput("sb_count", 32'(bus.event_count), 32'(e.ev));
    end
  endtask

  // From IDLE with the line quiet: raise alarm, accept, acknowledge, return to IDLE.
  task automatic fullAlarm(input logic [3:0] sens);
    t_sens = sens; t_alarm = 1'b1;
    applyStimulus(7);
    t_ack = 1'b1;
    applyStimulus(1);
    t_ack = 1'b0; t_alarm = 1'b0;
    applyStimulus(3);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit seen_active;

    rst = 1'b1;
    bus.alarm_in = 1'b0; bus.sensors_in = 4'd0; bus.arm = 1'b0;
    bus.ack = 1'b0; bus.clear_count = 1'b0;

    t_rst = 1'b1;
    applyStimulus(2);
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_siren", 32'(bus.siren), 32'd0);
    checkOutput("rst_count", 32'(bus.event_count), 32'd0);

    // Disarmed: alarm and ack held for 50 cycles have no effect.
    t_rst = 1'b0; t_arm = 1'b0; t_alarm = 1'b1; t_ack = 1'b1;
    applyStimulus(50);
    checkOutput("disarm_state", 32'(bus.state), 32'd0);
    checkOutput("disarm_count", 32'(bus.event_count), 32'd0);
    t_alarm = 1'b0; t_ack = 1'b0;
    t_rst = 1'b1;
    applyStimulus(1);
    t_rst = 1'b0;

    // Latency from alarm_in to alarm_active: 2 sync + 1 + 4 debounce.
    t_arm = 1'b1; t_alarm = 1'b1; t_sens = 4'b0101;
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (!bus.alarm_active && n < 20);
    checkOutput("latency", 32'(n), 32'd7);
    checkOutput("zone_0101", 32'(bus.zone), 32'h5);
    checkOutput("count_1", 32'(bus.event_count), 32'd1);
    checkOutput("siren_c0", 32'(bus.siren), 32'd1);

    // Siren shape over 24 ALARM cycles; disarming mid-alarm changes nothing.
    for (int i = 1; i < 24; i++) begin
      if (i == 10) t_arm = 1'b0;
      applyStimulus(1);
      checkOutput($sformatf("siren_c%0d", i), 32'(bus.siren), (i < 8 || i >= 16) ? 32'd1 : 32'd0);
    end
    checkOutput("alarm_disarm", 32'(bus.state), 32'd3);
    t_arm = 1'b1;

    t_ack = 1'b1;
    applyStimulus(1);
    checkOutput("ack_state", 32'(bus.state), 32'd4);
    checkOutput("ack_siren", 32'(bus.siren), 32'd0);
    checkOutput("ack_active", 32'(bus.alarm_active), 32'd0);
    t_ack = 1'b0; t_alarm = 1'b0;
    applyStimulus(2);
    checkOutput("acked_hold", 32'(bus.state), 32'd4);
    applyStimulus(1);
    checkOutput("acked_idle", 32'(bus.state), 32'd1);

    // Glitch shorter than the debounce window is rejected.
    seen_active = 1'b0;
    t_alarm = 1'b1; t_sens = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      seen_active |= bus.alarm_active;
    end
    t_alarm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      seen_active |= bus.alarm_active;
    end
    checkOutput("pulse_active", 32'(seen_active), 32'd0);
    checkOutput("pulse_state", 32'(bus.state), 32'd1);
    checkOutput("pulse_count", 32'(bus.event_count), 32'd1);

    // 255 more acceptances make 256 in total: counter saturates.
    for (int i = 0; i < 255; i++) begin
      fullAlarm(4'(i));
    end
    checkOutput("sat_count", 32'(bus.event_count), 32'd255);
    checkOutput("sat_state", 32'(bus.state), 32'd1);

    // Clear coinciding with an acceptance wins.
    t_alarm = 1'b1; t_sens = 4'b0011;
    applyStimulus(6);
    t_clr = 1'b1;
    applyStimulus(1);
    t_clr = 1'b0;
    checkOutput("clr_state", 32'(bus.state), 32'd3);
    checkOutput("clr_count", 32'(bus.event_count), 32'd0);
    checkOutput("clr_zone", 32'(bus.zone), 32'h3);
    t_ack = 1'b1;
    applyStimulus(1);
    t_ack = 1'b0; t_alarm = 1'b0;
    applyStimulus(3);

    // Reset in the first ALARM cycle with the siren on.
    t_alarm = 1'b1; t_sens = 4'b1010;
    applyStimulus(7);
    checkOutput("pre_rst_siren", 32'(bus.siren), 32'd1);
    checkOutput("pre_rst_count", 32'(bus.event_count), 32'd1);
    t_rst = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_siren", 32'(bus.siren), 32'd0);
    checkOutput("mid_rst_active", 32'(bus.alarm_active), 32'd0);
    checkOutput("mid_rst_state", 32'(bus.state), 32'd0);
    checkOutput("mid_rst_zone", 32'(bus.zone), 32'd0);
    checkOutput("mid_rst_count", 32'(bus.event_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
